gold_correlator: RTL and testbench

- Receive-side counterpart of the Gold code generator.
- Takes a serial chip stream, which is a Gold code XORed with one data bit per code period.
- Regenerates the same Gold code locally from two 6-bit LFSRs.
- Acquires code phase by serial search with chip slipping, tracks lock, and outputs one despread data bit per N-chip window plus a correlation score.

---
 rtl/gold_correlator.sv | 195 +++++++++++++++++++
 tb/tb_gold_correlator.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gold_correlator.sv
// Serial-search Gold code correlator: acquires code phase by chip slipping, tracks lock
// and despreads one data bit per N-chip window. Optional error counter: GOLD_CORR_ERRCNT_EN.
module gold_correlator #(
  parameter int                N         = 63,
  parameter int                LENGTH    = $clog2(N),
  parameter logic [LENGTH-1:0] POLY1     = 6'b000011,
  parameter logic [LENGTH-1:0] POLY2     = 6'b100111,
  parameter int                THRESH    = 56,
  parameter int                LOCK_MISS = 3
) (
  input  logic              clkin,
  input  logic              rstn,
  input  logic              chip_i,
  input  logic              chip_valid_i,
  input  logic [LENGTH-1:0] code_sel_i,
  input  logic              code_load_i,
  output logic              bit_o,
  output logic              bit_valid_o,
  output logic              lock_o,
`ifdef GOLD_CORR_ERRCNT_EN
  output logic [15:0]       err_cnt_o,
`endif
  output logic [LENGTH:0]   corr_o
);

  localparam int MISS_W = (LOCK_MISS > 2) ? $clog2(LOCK_MISS) : 1;
  localparam logic [LENGTH-1:0] L_LAST      = LENGTH'(N - 1);
  localparam logic [LENGTH-1:0] L_SEED      = LENGTH'(1);
  localparam logic [LENGTH:0]   L_HI        = (LENGTH + 1)'(THRESH);
  localparam logic [LENGTH:0]   L_LO        = (LENGTH + 1)'(N - THRESH);
  localparam logic [MISS_W-1:0] L_MISS_LAST = MISS_W'(LOCK_MISS - 1);

  typedef enum logic {
    SEARCH = 1'b0,
    TRACK  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [LENGTH-1:0] r_lfsr1;
  logic [LENGTH-1:0] r_lfsr2;
  logic [LENGTH-1:0] r_chip_cnt;
  logic [LENGTH:0]   r_agree;
  logic [MISS_W-1:0] r_miss;
  logic [MISS_W-1:0] w_miss_nxt;
  logic              r_slip;
  logic              w_slip_nxt;
  logic              r_bit;
  logic              w_bit_nxt;
  logic              r_bit_valid;
  logic              w_bit_valid_nxt;
  logic [LENGTH:0]   r_corr;
  logic [LENGTH:0]   w_corr_nxt;

  logic              w_g;
  logic              w_accept;
  logic              w_last;
  logic              w_agree_inc;
  logic [LENGTH:0]   w_final;
  logic              w_match0;
  logic              w_match1;
  logic              w_hit;
  logic              w_bit_dec;
  logic [LENGTH-1:0] w_seed2;
  logic [LENGTH-1:0] w_lfsr1_nxt;
  logic [LENGTH-1:0] w_lfsr2_nxt;

  assign w_g         = r_lfsr1[LENGTH-1] ^ r_lfsr2[LENGTH-1];
  assign w_lfsr1_nxt = {r_lfsr1[LENGTH-2:0], ^(r_lfsr1 & POLY1)};
  assign w_lfsr2_nxt = {r_lfsr2[LENGTH-2:0], ^(r_lfsr2 & POLY2)};
  assign w_seed2     = (code_sel_i == '0) ? L_SEED : code_sel_i;

  // A pending slip swallows the next valid chip; a reload swallows a coincident chip.
  assign w_accept    = chip_valid_i && !r_slip && !code_load_i;
  assign w_last      = w_accept && (r_chip_cnt == L_LAST);
  assign w_agree_inc = (chip_i == w_g);
  assign w_final     = r_agree + {{LENGTH{1'b0}}, w_agree_inc};
  assign w_match0    = (w_final >= L_HI);
  assign w_match1    = (w_final <= L_LO);
  assign w_hit       = w_match0 || w_match1;
  assign w_bit_dec   = !w_match0;

  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      r_lfsr1    <= L_SEED;
      r_lfsr2    <= L_SEED;
      r_chip_cnt <= '0;
      r_agree    <= '0;
    end else if (code_load_i) begin
      r_lfsr1    <= L_SEED;
      r_lfsr2    <= w_seed2;
      r_chip_cnt <= '0;
      r_agree    <= '0;
    end else if (w_accept) begin
      r_lfsr1 <= w_lfsr1_nxt;
      r_lfsr2 <= w_lfsr2_nxt;
      if (w_last) begin
        r_chip_cnt <= '0;
        r_agree    <= '0;
      end else begin
        r_chip_cnt <= r_chip_cnt + LENGTH'(1);
        r_agree    <= w_final;
      end
    end
  end

  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      r_state     <= SEARCH;
      r_miss      <= '0;
      r_slip      <= 1'b0;
      r_bit       <= 1'b0;
      r_bit_valid <= 1'b0;
      r_corr      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_miss      <= w_miss_nxt;
      r_slip      <= w_slip_nxt;
      r_bit       <= w_bit_nxt;
      r_bit_valid <= w_bit_valid_nxt;
      r_corr      <= w_corr_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_miss_nxt      = r_miss;
    w_slip_nxt      = r_slip;
    w_bit_nxt       = r_bit;
    w_bit_valid_nxt = 1'b0;
    w_corr_nxt      = r_corr;
    if (code_load_i) begin
      w_state_nxt = SEARCH;
      w_miss_nxt  = '0;
      w_slip_nxt  = 1'b0;
    end else if (chip_valid_i && r_slip) begin
      w_slip_nxt = 1'b0;
    end else if (w_last) begin
      w_corr_nxt = w_final;
      case (r_state)
        SEARCH: begin
          if (w_hit) begin
            w_state_nxt     = TRACK;
            w_bit_valid_nxt = 1'b1;
            w_bit_nxt       = w_bit_dec;
            w_miss_nxt      = '0;
          end else begin
            w_slip_nxt = 1'b1;
          end
        end
        TRACK: begin
          if (w_hit) begin
            w_bit_valid_nxt = 1'b1;
            w_bit_nxt       = w_bit_dec;
            w_miss_nxt      = '0;
          end else if (r_miss == L_MISS_LAST) begin
            w_state_nxt = SEARCH;
            w_miss_nxt  = '0;
            w_slip_nxt  = 1'b1;
          end else begin
            w_miss_nxt = r_miss + MISS_W'(1);
          end
        end
        default: w_state_nxt = SEARCH;
      endcase
    end
  end

`ifdef GOLD_CORR_ERRCNT_EN
  logic [15:0]     r_err;
  logic [LENGTH:0] w_err_add;
  logic [16:0]     w_err_sum;

  assign w_err_add = w_bit_dec ? w_final : ((LENGTH + 1)'(N) - w_final);
  assign w_err_sum = {1'b0, r_err} + 17'(w_err_add);

  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      r_err <= '0;
    end else if (code_load_i) begin
      r_err <= '0;
    end else if (w_last && (r_state == TRACK) && w_hit) begin
      r_err <= w_err_sum[16] ? '1 : w_err_sum[15:0];
    end
  end

  assign err_cnt_o = r_err;
`endif

  assign bit_o       = r_bit;
  assign bit_valid_o = r_bit_valid;
  assign lock_o      = (r_state == TRACK);
  assign corr_o      = r_corr;

endmodule

// File: tb/tb_gold_correlator.sv
// Directed bench for gold_correlator; reference code sequence built by a local LFSR model.
`timescale 1ns/1ps
module tb_gold_correlator;

  logic       clkin;
  logic       rstn;
  logic       chip_i;
  logic       chip_valid_i;
  logic [5:0] code_sel_i;
  logic       code_load_i;
  logic       bit_o;
  logic       bit_valid_o;
  logic       lock_o;
  logic [6:0] corr_o;
`ifdef GOLD_CORR_ERRCNT_EN
  logic [15:0] err_cnt_o;
`endif

  gold_correlator #(.N(63), .THRESH(56), .LOCK_MISS(3)) dut (
    .clkin        (clkin),
    .rstn         (rstn),
    .chip_i       (chip_i),
    .chip_valid_i (chip_valid_i),
    .code_sel_i   (code_sel_i),
    .code_load_i  (code_load_i),
    .bit_o        (bit_o),
    .bit_valid_o  (bit_valid_o),
    .lock_o       (lock_o),
`ifdef GOLD_CORR_ERRCNT_EN
    .err_cnt_o    (err_cnt_o),
`endif
    .corr_o       (corr_o)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   bv_seen = 0;
  int   li = 0;
  logic gseq [0:511];
  logic obs_bv, obs_bit, obs_lock;
  logic [6:0] obs_corr;
  logic prev_bv = 1'b0;

  always @(negedge clkin) begin
    if (rstn && bit_valid_o) begin
      n_cmp++;
      if (prev_bv) begin
        n_bad++;
        $display("FAIL bv_strobe: got two consecutive bit_valid_o cycles, want single-cycle strobe");
      end
    end
    prev_bv = bit_valid_o;
  end

  task automatic build_code(input logic [5:0] seed);
    logic [5:0] s1, s2;
    s1 = 6'b000001;
    s2 = seed;
    for (int k = 0; k < 512; k++) begin
      gseq[k] = s1[5] ^ s2[5];
      s1 = {s1[4:0], ^(s1 & 6'b000011)};
      s2 = {s2[4:0], ^(s2 & 6'b100111)};
    end
  endtask

  // Observe outputs produced by the previous edge, then drive the next cycle's inputs.
  task automatic step(input logic v, input logic c, input logic ld);
    @(negedge clkin);
    obs_bv   = bit_valid_o;
    obs_bit  = bit_o;
    obs_lock = lock_o;
    obs_corr = corr_o;
    if (obs_bv) bv_seen++;
    chip_valid_i = v;
    chip_i       = c;
    code_load_i  = ld;
  endtask

  task automatic do_load(input logic [5:0] sel);
    code_sel_i = sel;
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    li = 0;
  endtask

  task automatic send_aligned(input logic inv);
    for (int k = 0; k < 63; k++) begin
      step(1'b1, gseq[li] ^ inv, 1'b0);
      li++;
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0; chip_i = 1'b0; chip_valid_i = 1'b0; code_sel_i = '0; code_load_i = 1'b0;
    repeat (3) @(negedge clkin);
    n_cmp++; if (bit_o !== 1'b0)       begin n_bad++; $display("FAIL reset_bit: got %b want 0", bit_o); end
    n_cmp++; if (bit_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_bv: got %b want 0", bit_valid_o); end
    n_cmp++; if (lock_o !== 1'b0)      begin n_bad++; $display("FAIL reset_lock: got %b want 0", lock_o); end
    n_cmp++; if (corr_o !== 7'd0)      begin n_bad++; $display("FAIL reset_corr: got %0d want 0", corr_o); end
`ifdef GOLD_CORR_ERRCNT_EN
    n_cmp++; if (err_cnt_o !== 16'd0)  begin n_bad++; $display("FAIL reset_err: got %0d want 0", err_cnt_o); end
`endif
    rstn = 1'b1;
  endtask

  task automatic test_aligned(input logic data);
    int snap;
    build_code(6'b000001);
    do_load(6'b000001);
    snap = bv_seen;
    send_aligned(data);
    n_cmp++; if (bv_seen !== snap) begin n_bad++; $display("FAIL aligned%0d_early_bv: got %0d strobes want 0", data, bv_seen - snap); end
    step(1'b0, 1'b0, 1'b0);
    n_cmp++; if (obs_bv !== 1'b1)   begin n_bad++; $display("FAIL aligned%0d_bv: got %b want 1", data, obs_bv); end
    n_cmp++; if (obs_bit !== data)  begin n_bad++; $display("FAIL aligned%0d_bit: got %b want %b", data, obs_bit, data); end
    n_cmp++; if (obs_corr !== (data ? 7'd0 : 7'd63)) begin n_bad++; $display("FAIL aligned%0d_corr: got %0d want %0d", data, obs_corr, data ? 0 : 63); end
    n_cmp++; if (obs_lock !== 1'b1) begin n_bad++; $display("FAIL aligned%0d_lock: got %b want 1", data, obs_lock); end
    step(1'b0, 1'b0, 1'b0);
    n_cmp++; if (obs_bv !== 1'b0)   begin n_bad++; $display("FAIL aligned%0d_bv_drop: got %b want 0", data, obs_bv); end
  endtask

  // Received stream lags the local code by one chip: one slip after window 1 aligns it.
  task automatic test_slip;
    int a1;
    logic c;
    build_code(6'b000001);
    do_load(6'b000001);
    a1 = (gseq[62] == gseq[0]) ? 1 : 0;
    for (int k = 1; k < 63; k++) a1 += (gseq[k-1] == gseq[k]) ? 1 : 0;
    for (int j = 0; j < 127; j++) begin
      c = (j == 0) ? gseq[62] : gseq[j-1];
      step(1'b1, c, 1'b0);
      if (j == 63) begin
        n_cmp++; if (obs_bv !== 1'b0)   begin n_bad++; $display("FAIL slip_w1_bv: got %b want 0", obs_bv); end
        n_cmp++; if (obs_lock !== 1'b0) begin n_bad++; $display("FAIL slip_w1_lock: got %b want 0", obs_lock); end
        n_cmp++; if (obs_corr !== 7'(a1)) begin n_bad++; $display("FAIL slip_w1_corr: got %0d want %0d", obs_corr, a1); end
      end
    end
    step(1'b0, 1'b0, 1'b0);
    li = 126;
    n_cmp++; if (obs_bv !== 1'b1)    begin n_bad++; $display("FAIL slip_w2_bv: got %b want 1", obs_bv); end
    n_cmp++; if (obs_bit !== 1'b0)   begin n_bad++; $display("FAIL slip_w2_bit: got %b want 0", obs_bit); end
    n_cmp++; if (obs_corr !== 7'd63) begin n_bad++; $display("FAIL slip_w2_corr: got %0d want 63", obs_corr); end
    n_cmp++; if (obs_lock !== 1'b1)  begin n_bad++; $display("FAIL slip_w2_lock: got %b want 1", obs_lock); end
  endtask

  // Every odd chip inverted: 32, 31, 32 agreements in the three windows.
  task automatic test_lock_loss;
    int snap;
    snap = bv_seen;
    for (int k = 0; k < 189; k++) begin
      step(1'b1, gseq[li] ^ k[0], 1'b0);
      li++;
      if (k == 63) begin
        n_cmp++; if (obs_lock !== 1'b1)  begin n_bad++; $display("FAIL loss_w1_lock: got %b want 1", obs_lock); end
        n_cmp++; if (obs_corr !== 7'd32) begin n_bad++; $display("FAIL loss_w1_corr: got %0d want 32", obs_corr); end
      end
      if (k == 126) begin
        n_cmp++; if (obs_lock !== 1'b1)  begin n_bad++; $display("FAIL loss_w2_lock: got %b want 1", obs_lock); end
        n_cmp++; if (obs_corr !== 7'd31) begin n_bad++; $display("FAIL loss_w2_corr: got %0d want 31", obs_corr); end
      end
    end
    step(1'b1, 1'b1, 1'b0);
    n_cmp++; if (obs_lock !== 1'b0)  begin n_bad++; $display("FAIL loss_w3_lock: got %b want 0", obs_lock); end
    n_cmp++; if (obs_corr !== 7'd32) begin n_bad++; $display("FAIL loss_w3_corr: got %0d want 32", obs_corr); end
    n_cmp++; if (bv_seen !== snap)   begin n_bad++; $display("FAIL loss_bv: got %0d strobes want 0", bv_seen - snap); end
    send_aligned(1'b0);
    step(1'b0, 1'b0, 1'b0);
    n_cmp++; if (obs_bv !== 1'b1)    begin n_bad++; $display("FAIL reacq_bv: got %b want 1", obs_bv); end
    n_cmp++; if (obs_corr !== 7'd63) begin n_bad++; $display("FAIL reacq_corr: got %0d want 63", obs_corr); end
    n_cmp++; if (obs_lock !== 1'b1)  begin n_bad++; $display("FAIL reacq_lock: got %b want 1", obs_lock); end
  endtask

  task automatic test_chip_errors;
    logic e;
    for (int k = 0; k < 63; k++) begin
      e = (k == 3) || (k == 10) || (k == 20) || (k == 40);
      step(1'b1, gseq[li] ^ e, 1'b0);
      li++;
    end
    step(1'b0, 1'b0, 1'b0);
    n_cmp++; if (obs_bv !== 1'b1)    begin n_bad++; $display("FAIL err_bv: got %b want 1", obs_bv); end
    n_cmp++; if (obs_bit !== 1'b0)   begin n_bad++; $display("FAIL err_bit: got %b want 0", obs_bit); end
    n_cmp++; if (obs_corr !== 7'd59) begin n_bad++; $display("FAIL err_corr: got %0d want 59", obs_corr); end
    n_cmp++; if (obs_lock !== 1'b1)  begin n_bad++; $display("FAIL err_lock: got %b want 1", obs_lock); end
`ifdef GOLD_CORR_ERRCNT_EN
    n_cmp++; if (err_cnt_o !== 16'd4) begin n_bad++; $display("FAIL err_cnt: got %0d want 4", err_cnt_o); end
`endif
  endtask

  task automatic test_load_mid_window;
    for (int k = 0; k < 20; k++) begin
      step(1'b1, gseq[li], 1'b0);
      li++;
    end
    code_sel_i = 6'b000101;
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    n_cmp++; if (obs_lock !== 1'b0) begin n_bad++; $display("FAIL load_lock: got %b want 0", obs_lock); end
    n_cmp++; if (obs_bv !== 1'b0)   begin n_bad++; $display("FAIL load_bv: got %b want 0", obs_bv); end
`ifdef GOLD_CORR_ERRCNT_EN
    n_cmp++; if (err_cnt_o !== 16'd0) begin n_bad++; $display("FAIL load_err_clr: got %0d want 0", err_cnt_o); end
`endif
    build_code(6'b000101);
    li = 0;
    send_aligned(1'b0);
    step(1'b0, 1'b0, 1'b0);
    n_cmp++; if (obs_bv !== 1'b1)    begin n_bad++; $display("FAIL load_new_bv: got %b want 1", obs_bv); end
    n_cmp++; if (obs_corr !== 7'd63) begin n_bad++; $display("FAIL load_new_corr: got %0d want 63", obs_corr); end
    n_cmp++; if (obs_lock !== 1'b1)  begin n_bad++; $display("FAIL load_new_lock: got %b want 1", obs_lock); end
  endtask

  // A zero selector must fall back to the 000001 seed.
  task automatic test_seed_zero;
    build_code(6'b000001);
    do_load(6'b000000);
    send_aligned(1'b1);
    step(1'b0, 1'b0, 1'b0);
    n_cmp++; if (obs_bv !== 1'b1)   begin n_bad++; $display("FAIL seed0_bv: got %b want 1", obs_bv); end
    n_cmp++; if (obs_bit !== 1'b1)  begin n_bad++; $display("FAIL seed0_bit: got %b want 1", obs_bit); end
    n_cmp++; if (obs_corr !== 7'd0) begin n_bad++; $display("FAIL seed0_corr: got %0d want 0", obs_corr); end
  endtask

  task automatic test_reset_mid_window;
    for (int k = 0; k < 10; k++) begin
      step(1'b1, gseq[li], 1'b0);
      li++;
    end
    @(negedge clkin);
    rstn = 1'b0;
    #1;
    n_cmp++; if (lock_o !== 1'b0)      begin n_bad++; $display("FAIL rst_mid_lock: got %b want 0", lock_o); end
    n_cmp++; if (corr_o !== 7'd0)      begin n_bad++; $display("FAIL rst_mid_corr: got %0d want 0", corr_o); end
    n_cmp++; if (bit_o !== 1'b0)       begin n_bad++; $display("FAIL rst_mid_bit: got %b want 0", bit_o); end
    n_cmp++; if (bit_valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_mid_bv: got %b want 0", bit_valid_o); end
    chip_valid_i = 1'b0;
    code_load_i  = 1'b0;
    repeat (2) @(negedge clkin);
    rstn = 1'b1;
    repeat (2) @(negedge clkin);
  endtask

  initial begin
    test_reset();
    test_aligned(1'b0);
    test_aligned(1'b1);
    test_slip();
    test_lock_loss();
    test_chip_errors();
    test_load_mid_window();
    test_seed_zero();
    test_aligned(1'b0);
    test_reset_mid_window();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
